// File: rtl/iterative_divide.sv
// iterative_divide
//   Multi-cycle radix-2 restoring divider. It returns dividend/divisor as an
//   unsigned Q0.OUT_WIDTH fraction and carries an opaque tag from request to
//   result.
//
// Build option:
//   ITERATIVE_DIVIDE_ROUND_EN - compute one guard bit and round half-up.
//     When the rounding increment would overflow, the quotient clamps to all
//     ones and saturated is set. Normal-path latency becomes OUT_WIDTH+1.
//     Without the macro the quotient is truncated and the latency is
//     OUT_WIDTH.
//
// Handshake (both sides): a transfer occurs on a rising clock edge where
//   valid && ready. in_ready is high only in IDLE and out_valid is high only
//   in DONE. The upstream holds its request until in_ready. While
//   out_valid && !out_ready, all result outputs hold stable.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high
//   in_valid    request valid
//   in_ready    block can accept a request (IDLE)
//   dividend    numerator, WIDTH bits, unsigned
//   divisor     denominator, WIDTH bits, unsigned
//   in_tag      request tag
//   out_valid   result valid (DONE)
//   out_ready   consumer accepts the result
//   quotient    floor(dividend*2^OUT_WIDTH/divisor), saturated to all ones
//   out_tag     tag of the result
//   saturated   dividend >= divisor (or rounding overflow); quotient all ones
//   div_by_zero divisor was zero; quotient all ones
//
// The FSM state is available as the internal signal 'state' (state_t).
module iterative_divide #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 16,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] quotient,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 saturated,
    output logic                 div_by_zero
);

`ifdef ITERATIVE_DIVIDE_ROUND_EN
    localparam int ITER = OUT_WIDTH + 1;
`else
    localparam int ITER = OUT_WIDTH;
`endif
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH:0]     rem;        // partial remainder, always < 2*divisor
    logic [WIDTH-1:0]   divisor_r;
    logic [ITER-1:0]    q_sr;       // quotient shift register
    logic [CW-1:0]      iter_cnt;

    logic               accept;
    logic               fast_zero;
    logic               fast_sat;
    logic               last_iter;

    logic [WIDTH:0]     rem_shift;
    logic               q_bit;
    logic [WIDTH:0]     rem_next;
    logic [ITER-1:0]    q_next;
    logic [OUT_WIDTH-1:0] q_final;
    logic               sat_final;

    assign accept    = in_valid && in_ready;
    assign fast_zero = (divisor == '0);
    assign fast_sat  = (dividend >= divisor);
    assign last_iter = (state == BUSY) && (iter_cnt == CW'(1));

    // One restoring step. rem < divisor on entry, so the shift never loses
    // a set bit and the compare fits in WIDTH+1 bits.
    always_comb begin
        rem_shift = rem << 1;
        q_bit     = (rem_shift >= {1'b0, divisor_r});
        rem_next  = q_bit ? (rem_shift - {1'b0, divisor_r}) : rem_shift;
        q_next    = (q_sr << 1) | ITER'(q_bit);
    end

`ifdef ITERATIVE_DIVIDE_ROUND_EN
    // LSB of q_next is the guard bit; add it to the truncated quotient.
    logic [OUT_WIDTH-1:0] q_trunc;
    logic                 guard;
    logic                 round_ovf;
    always_comb begin
        q_trunc   = q_next[ITER-1:1];
        guard     = q_next[0];
        round_ovf = guard && (&q_trunc);
        q_final   = round_ovf ? '1 : (q_trunc + OUT_WIDTH'(guard));
        sat_final = round_ovf;
    end
`else
    always_comb begin
        q_final   = q_next[OUT_WIDTH-1:0];
        sat_final = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (fast_zero || fast_sat) begin
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (iter_cnt == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem         <= '0;
            divisor_r   <= '0;
            q_sr        <= '0;
            iter_cnt    <= '0;
            quotient    <= '0;
            out_tag     <= '0;
            saturated   <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            rem       <= {1'b0, dividend};
            divisor_r <= divisor;
            q_sr      <= '0;
            iter_cnt  <= CW'(ITER);
            out_tag   <= in_tag;
            if (fast_zero) begin
                quotient    <= '1;
                saturated   <= 1'b0;
                div_by_zero <= 1'b1;
            end else if (fast_sat) begin
                quotient    <= '1;
                saturated   <= 1'b1;
                div_by_zero <= 1'b0;
            end else begin
                saturated   <= 1'b0;
                div_by_zero <= 1'b0;
            end
        end else if (state == BUSY) begin
            rem      <= rem_next;
            q_sr     <= q_next;
            iter_cnt <= iter_cnt - CW'(1);
            if (last_iter) begin
                quotient  <= q_final;
                saturated <= sat_final;
            end
        end
    end

endmodule

// File: tb/tb_iterative_divide.sv
// Directed bench for iterative_divide with WIDTH=8, OUT_WIDTH=8, TAG_WIDTH=4.
// Expected values are hand-computed. Round-dependent values follow the
// ITERATIVE_DIVIDE_ROUND_EN macro.
module tb_iterative_divide;

`ifdef ITERATIVE_DIVIDE_ROUND_EN
    localparam int       LAT    = 9;
    localparam bit [7:0] EXP_23 = 8'hAB;
`else
    localparam int       LAT    = 8;
    localparam bit [7:0] EXP_23 = 8'hAA;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic [3:0] in_tag = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] quotient;
    logic [3:0] out_tag;
    logic       saturated;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    iterative_divide #(.WIDTH(8), .OUT_WIDTH(8), .TAG_WIDTH(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .out_tag(out_tag),
        .saturated(saturated), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request, wait (bounded) for in_ready, return just after the
    // accepting edge with in_valid dropped.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
        int n;
        dividend = a;
        divisor  = b;
        in_tag   = tag;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
            errors++;
        end
        step();
        in_valid = 1'b0;
    endtask

    // One full transaction with out_ready=1. exp_lat is the number of edges
    // after the accepting edge until out_valid is seen (0: right after it).
    task automatic run_one(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] tag, input logic [7:0] exp_q, input int exp_lat,
                           input logic exp_sat, input logic exp_dbz);
        int edges;
        out_ready = 1'b1;
        issue(a, b, tag);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 100) begin
            step();
            edges++;
        end
        checks++;
        if (edges !== exp_lat) begin
            $display("FAIL %s latency: got %0d edges required %0d", name, edges, exp_lat);
            errors++;
        end
        checks++;
        if (quotient !== exp_q) begin
            $display("FAIL %s quotient: got %02h required %02h", name, quotient, exp_q);
            errors++;
        end
        checks++;
        if (out_tag !== tag) begin
            $display("FAIL %s out_tag: got %0d required %0d", name, out_tag, tag);
            errors++;
        end
        checks++;
        if ({saturated, div_by_zero} !== {exp_sat, exp_dbz}) begin
            $display("FAIL %s flags: got sat=%b dbz=%b required sat=%b dbz=%b",
                     name, saturated, div_by_zero, exp_sat, exp_dbz);
            errors++;
        end
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL %s after_handshake: got out_valid=%b in_ready=%b required 0 1",
                     name, out_valid, in_ready);
            errors++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL reset_handshake: got in_ready=%b out_valid=%b required 1 0",
                     in_ready, out_valid);
            errors++;
        end
        checks++;
        if ({quotient, out_tag, saturated, div_by_zero} !== 14'd0) begin
            $display("FAIL reset_outputs: got q=%02h tag=%0d sat=%b dbz=%b required all 0",
                     quotient, out_tag, saturated, div_by_zero);
            errors++;
        end
    endtask

    task automatic test_normal();
        run_one("one_third", 8'd1, 8'd3, 4'd5, 8'h55, LAT, 1'b0, 1'b0);
        run_one("two_thirds", 8'd2, 8'd3, 4'd2, EXP_23, LAT, 1'b0, 1'b0);
        run_one("zero_dividend", 8'd0, 8'd9, 4'd9, 8'h00, LAT, 1'b0, 1'b0);
        run_one("one_half", 8'd100, 8'd200, 4'd1, 8'h80, LAT, 1'b0, 1'b0);
    endtask

    task automatic test_fast_paths();
        run_one("div_by_zero", 8'd7, 8'd0, 4'd3, 8'hFF, 0, 1'b0, 1'b1);
        run_one("equal_sat", 8'd200, 8'd200, 4'd4, 8'hFF, 0, 1'b1, 1'b0);
        run_one("big_sat", 8'd255, 8'd1, 4'd15, 8'hFF, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        int edges;
        out_ready = 1'b0;
        issue(8'd1, 8'd3, 4'd3);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 100) begin
            step();
            edges++;
        end
        // New request waits upstream while the result is held.
        dividend = 8'd2;
        divisor  = 8'd3;
        in_tag   = 4'd6;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({out_valid, in_ready, quotient, out_tag} !== {1'b1, 1'b0, 8'h55, 4'd3}) begin
                $display("FAIL bp_hold cycle %0d: got v=%b r=%b q=%02h tag=%0d required 1 0 55 3",
                         i, out_valid, in_ready, quotient, out_tag);
                errors++;
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL bp_release: got out_valid=%b in_ready=%b required 0 1",
                     out_valid, in_ready);
            errors++;
        end
        step();
        in_valid = 1'b0;
        edges = 0;
        while (out_valid !== 1'b1 && edges < 100) begin
            step();
            edges++;
        end
        checks++;
        if ({quotient, out_tag} !== {EXP_23, 4'd6} || edges !== LAT) begin
            $display("FAIL bp_next: got q=%02h tag=%0d lat=%0d required %02h 6 %0d",
                     quotient, out_tag, edges, EXP_23, LAT);
            errors++;
        end
        step();
    endtask

    task automatic test_reset_busy();
        int stale;
        out_ready = 1'b1;
        issue(8'd2, 8'd3, 4'd7);
        step();
        step();
        step();
        reset = 1'b1;          // sampled on the 4th iteration edge
        step();
        reset = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL reset_busy: got in_ready=%b out_valid=%b required 1 0",
                     in_ready, out_valid);
            errors++;
        end
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin
            $display("FAIL reset_busy_stale: got %0d out_valid cycles required 0", stale);
            errors++;
        end
        run_one("after_reset", 8'd1, 8'd3, 4'd8, 8'h55, LAT, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_fast_paths();
        test_backpressure();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
